sva_attempt_scheduler: RTL

Sequences a single shared assertion-evaluation engine across a fixed pool of concurrent attempt slots. On every `step_pulse` (one per user-clock sample), it presents each live attempt to the evaluator in ascending slot order. It then launches a new attempt from the initial state into the lowest free slot. Finally it retires slots on success, failure or lazy-success and keeps outcome statistics. It sits between the gclk edge/strobe logic and the per-attempt next-state function.

---
 rtl/sva_attempt_scheduler_if.sv | 27 ++
 rtl/sva_attempt_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sva_attempt_scheduler_if.sv
// Evaluator handshake between the attempt scheduler (master) and the shared
// next-state engine (slave).
interface sva_attempt_scheduler_if #(
  parameter int NUM_SLOTS = 4,
  parameter int STATE_W   = 4,
  parameter int TS_W      = 16
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic               eval_req;
  logic [SLOT_W-1:0]  eval_slot;
  logic [STATE_W-1:0] eval_state;
  logic [TS_W-1:0]    eval_ts;
  logic               eval_ack;
  logic [STATE_W-1:0] eval_next;
  logic [1:0]         eval_kind;

  modport master (
    output eval_req, eval_slot, eval_state, eval_ts,
    input  eval_ack, eval_next, eval_kind
  );

  modport slave (
    input  eval_req, eval_slot, eval_state, eval_ts,
    output eval_ack, eval_next, eval_kind
  );
endinterface

// File: rtl/sva_attempt_scheduler.sv
// Time-multiplexes one assertion evaluator over a pool of attempt slots:
// per step, evaluate live slots in ascending order, then launch one new attempt.
module sva_attempt_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int STATE_W    = 4,
  parameter int INIT_STATE = 0,
  parameter int TS_W       = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  gclk,
  input  logic                  grst,
  input  logic                  step_pulse,
  input  logic                  start_en,
  sva_attempt_scheduler_if.master ev,
  output logic                  busy,
  output logic [NUM_SLOTS-1:0]  active_mask,
  output logic [TS_W-1:0]       step_cnt,
  output logic [CNT_W-1:0]      succ_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [CNT_W-1:0]      lazy_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  overrun
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  // state  | meaning: IDLE wait for step, SCAN pick next pending slot,
  //          WAIT hold request until ack, LAUNCH place new attempt in a free slot
  typedef enum logic [1:0] {IDLE, SCAN, WAIT, LAUNCH} fsm_e;

  localparam logic [1:0] KIND_CONT = 2'b00;
  localparam logic [1:0] KIND_SUCC = 2'b01;
  localparam logic [1:0] KIND_FAIL = 2'b10;

  fsm_e               state_q;
  logic [NUM_SLOTS-1:0] active_q;
  logic [NUM_SLOTS-1:0] pend_q;
  logic [STATE_W-1:0] slot_state_q [NUM_SLOTS];
  logic [TS_W-1:0]    slot_ts_q    [NUM_SLOTS];
  logic               launch_pend_q;
  logic               launched_q;
  logic [TS_W-1:0]    cur_ts_q;
  logic [TS_W-1:0]    step_cnt_q;
  logic [CNT_W-1:0]   succ_cnt_q, fail_cnt_q, lazy_cnt_q, drop_cnt_q;
  logic               overrun_q;
  logic               eval_req_q;
  logic [SLOT_W-1:0]  eval_slot_q;
  logic [STATE_W-1:0] eval_state_q;
  logic [TS_W-1:0]    eval_ts_q;

  logic               pend_found_d, free_found_d;
  logic [SLOT_W-1:0]  pend_idx_d, free_idx_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    pend_found_d = 1'b0;
    pend_idx_d   = '0;
    free_found_d = 1'b0;
    free_idx_d   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        pend_found_d = 1'b1;
        pend_idx_d   = SLOT_W'(i);
      end
      if (!active_q[i]) begin
        free_found_d = 1'b1;
        free_idx_d   = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_q       <= IDLE;
      active_q      <= '0;
      pend_q        <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_state_q[i] <= '0;
        slot_ts_q[i]    <= '0;
      end
      launch_pend_q <= 1'b0;
      launched_q    <= 1'b0;
      cur_ts_q      <= '0;
      step_cnt_q    <= '0;
      succ_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      lazy_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      overrun_q     <= 1'b0;
      eval_req_q    <= 1'b0;
      eval_slot_q   <= '0;
      eval_state_q  <= '0;
      eval_ts_q     <= '0;
    end else begin
      if (step_pulse && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (step_pulse) begin
            pend_q        <= active_q;
            launch_pend_q <= start_en;
            launched_q    <= 1'b0;
            cur_ts_q      <= step_cnt_q;
            step_cnt_q    <= step_cnt_q + 1'b1;
            state_q       <= SCAN;
          end
        end
        SCAN: begin
          if (pend_found_d) begin
            eval_req_q   <= 1'b1;
            eval_slot_q  <= pend_idx_d;
            eval_state_q <= slot_state_q[pend_idx_d];
            eval_ts_q    <= slot_ts_q[pend_idx_d];
            state_q      <= WAIT;
          end else if (launch_pend_q && !launched_q) begin
            state_q <= LAUNCH;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (ev.eval_ack) begin
            eval_req_q          <= 1'b0;
            pend_q[eval_slot_q] <= 1'b0;
            case (ev.eval_kind)
              KIND_CONT: slot_state_q[eval_slot_q] <= ev.eval_next;
              KIND_SUCC: begin
                active_q[eval_slot_q] <= 1'b0;
                succ_cnt_q            <= sat_inc(succ_cnt_q);
              end
              KIND_FAIL: begin
                active_q[eval_slot_q] <= 1'b0;
                fail_cnt_q            <= sat_inc(fail_cnt_q);
              end
              default: begin
                active_q[eval_slot_q] <= 1'b0;
                lazy_cnt_q            <= sat_inc(lazy_cnt_q);
              end
            endcase
            state_q <= SCAN;
          end
        end
        LAUNCH: begin
          launched_q <= 1'b1;
          // Setting the pend bit makes the new attempt the last evaluation of this step.
          if (free_found_d) begin
            active_q[free_idx_d]     <= 1'b1;
            slot_state_q[free_idx_d] <= STATE_W'(INIT_STATE);
            slot_ts_q[free_idx_d]    <= cur_ts_q;
            pend_q[free_idx_d]       <= 1'b1;
          end else begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
          end
          state_q <= SCAN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ev.eval_req   = eval_req_q;
  assign ev.eval_slot  = eval_slot_q;
  assign ev.eval_state = eval_state_q;
  assign ev.eval_ts    = eval_ts_q;

  assign busy        = (state_q != IDLE);
  assign active_mask = active_q;
  assign step_cnt    = step_cnt_q;
  assign succ_cnt    = succ_cnt_q;
  assign fail_cnt    = fail_cnt_q;
  assign lazy_cnt    = lazy_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign overrun     = overrun_q;
endmodule
